// File: rtl/dsqw_irq_ctrl_mc_pkg.sv
// Shared constants for the multi-channel deskew interrupt controller.
// This package holds the FSM state encoding, the default widths and the
// irq_cause width helper.
package dsqw_irq_pkg;

    localparam int DEF_N_SRC = 3;
    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // Width of a source index; never below 1 so that N_SRC=1 still has a port.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dsqw_irq_ctrl_mc_if.sv
// Register-block side bundle of the interrupt controller.
// The slave modport is the controller, and the master modport is the register block.
interface dsqw_irq_ctrl_mc_if #(
    parameter int N_SRC = 3,
    parameter int CNT_W = 8,
    parameter int IDX_W = 2
);
    logic [N_SRC-1:0] src;
    logic [N_SRC-1:0] ack;
    logic [N_SRC-1:0] en;
    logic [N_SRC-1:0] edge_mode;
    logic [CNT_W-1:0] holdoff_cycles;
    logic [N_SRC-1:0] pending;
    logic             irq;
    logic [IDX_W-1:0] irq_cause;
    logic [N_SRC-1:0] ovf;

    modport slave (
        input  src, ack, en, edge_mode, holdoff_cycles,
        output pending, irq, irq_cause, ovf
    );

    modport master (
        output src, ack, en, edge_mode, holdoff_cycles,
        input  pending, irq, irq_cause, ovf
    );
endinterface

// File: rtl/dsqw_irq_ctrl_mc_chan.sv
// One interrupt channel. It holds the delayed source, the edge/level event
// detect, the sticky pending bit and the optional overflow flag.
// Define DSQW_IRQ_OVF_EN to store overflow flags. Otherwise ovf_o is tied low.
module dsqw_irq_chan (
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    input  logic ack_i,
    input  logic edge_mode_i,
    output logic pending_o,
    output logic ovf_o
);
    logic src_d_q, src_d_d;
    logic pending_q, pending_d;
    logic evt;

    assign evt = edge_mode_i ? (src_i & ~src_d_q) : src_i;

    // Ack beats a coincident event; that event is dropped.
    always_comb begin
        src_d_d   = src_i;
        pending_d = pending_q;
        if (ack_i)    pending_d = 1'b0;
        else if (evt) pending_d = 1'b1;
    end

    // Delayed source and pending bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_d_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            src_d_q   <= src_d_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

`ifdef DSQW_IRQ_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow is an event landing on a set bit or on an ack. A new set wins over the ack.
    always_comb begin
        ovf_d = ovf_q;
        if (evt & (pending_q | ack_i)) ovf_d = 1'b1;
        else if (ack_i)                ovf_d = 1'b0;
    end

    // Sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/dsqw_irq_ctrl_mc.sv
// Multi-channel sticky interrupt controller.
// It contains N_SRC channels, a priority encode of the enabled pending bits,
// and an IDLE/ASSERT/HOLD FSM with a hold-off counter that drives a registered irq.
// Optional overflow storage in the channels is enabled with DSQW_IRQ_OVF_EN.
module dsqw_irq_ctrl_mc
    import dsqw_irq_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int CNT_W = DEF_CNT_W,
    parameter int IDX_W = idx_w(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    dsqw_irq_ctrl_mc_if.slave bus
);
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] ovf;
    logic [N_SRC-1:0] masked;
    logic             active;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic [IDX_W-1:0] cause_q, cause_d;

    for (genvar g = 0; g < N_SRC; g++) begin : g_chan
        dsqw_irq_chan u_chan (
            .clk         (clk),
            .rst         (rst),
            .src_i       (bus.src[g]),
            .ack_i       (bus.ack[g]),
            .edge_mode_i (bus.edge_mode[g]),
            .pending_o   (pending[g]),
            .ovf_o       (ovf[g])
        );
    end

    // Lowest enabled pending index wins; the search runs high to low so the last hit is the lowest.
    always_comb begin
        masked  = pending & bus.en;
        active  = |masked;
        cause_d = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) cause_d = IDX_W'(i);
        end
    end

    // The hold-off length is latched only when HOLD is entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (active) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (!active) begin
                    if (bus.holdoff_cycles != '0) begin
                        state_d = ST_HOLD;
                        cnt_d   = bus.holdoff_cycles;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        irq_d = (state_d == ST_ASSERT);
    end

    // FSM, counter, irq and cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            cause_q <= cause_d;
        end
    end

    assign bus.pending   = pending;
    assign bus.irq       = irq_q;
    assign bus.irq_cause = cause_q;
    assign bus.ovf       = ovf;

endmodule

// File: tb/tb_dsqw_irq_ctrl_mc.sv
// Directed bench for dsqw_irq_ctrl_mc with N_SRC=3.
// Overflow expectations follow DSQW_IRQ_OVF_EN.
module tb_dsqw_irq_ctrl_mc;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   low;

    always #5 clk = ~clk;

    dsqw_irq_ctrl_mc_if #(.N_SRC(3), .CNT_W(8), .IDX_W(2)) bus ();

    dsqw_irq_ctrl_mc #(.N_SRC(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef DSQW_IRQ_OVF_EN
    localparam logic [2:0] OVF_CH2 = 3'b100;
    localparam logic [2:0] OVF_CH0 = 3'b001;
`else
    localparam logic [2:0] OVF_CH2 = 3'b000;
    localparam logic [2:0] OVF_CH0 = 3'b000;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.src = '0; bus.ack = '0; bus.en = 3'b111; bus.edge_mode = '0;
        bus.holdoff_cycles = '0;
        step(); step();
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_irq", 32'(bus.irq), 0);
        chk("rst_cause", 32'(bus.irq_cause), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0;
        step();

        // Level path on ch1
        bus.src = 3'b010; step();
        chk("lvl_pend", 32'(bus.pending), 32'h2);
        chk("lvl_irq_early", 32'(bus.irq), 0);
        bus.src = '0; step();
        chk("lvl_irq", 32'(bus.irq), 1);
        chk("lvl_cause", 32'(bus.irq_cause), 1);
        bus.ack = 3'b010; step();
        chk("lvl_ack_pend", 32'(bus.pending), 0);
        chk("lvl_ack_irq", 32'(bus.irq), 1);
        bus.ack = '0; step();
        chk("lvl_irq_drop", 32'(bus.irq), 0);
        chk("lvl_cause_clr", 32'(bus.irq_cause), 0);

        // Edge mode on ch0, held high 10 cycles, ack at cycle 4
        bus.edge_mode = 3'b001; bus.src = 3'b001; step();
        chk("edge_pend", 32'(bus.pending), 32'h1);
        step();
        chk("edge_irq", 32'(bus.irq), 1);
        step();
        bus.ack = 3'b001; step();
        chk("edge_ack", 32'(bus.pending), 0);
        bus.ack = '0;
        for (int c = 5; c <= 10; c++) begin
            step();
            chk("edge_hold_pend", 32'(bus.pending), 0);
        end
        chk("edge_no_reirq", 32'(bus.irq), 0);
        bus.src = '0; bus.edge_mode = '0; step();

        // Simultaneous ack and event on ch2
        bus.src = 3'b100; bus.ack = 3'b100; step();
        chk("coinc_pend", 32'(bus.pending), 0);
        chk("coinc_ovf", 32'(bus.ovf), 32'(OVF_CH2));
        bus.src = '0; step();
        chk("coinc_irq", 32'(bus.irq), 0);
        chk("ovf_clr_ch2", 32'(bus.ovf), 0);
        bus.ack = '0;

        // Level event on an already-pending ch0
        bus.src = 3'b001; step(); step();
        chk("ovf_repeat", 32'(bus.ovf), 32'(OVF_CH0));
        bus.src = '0; bus.ack = 3'b001; step();
        chk("ovf_ack_pend", 32'(bus.pending), 0);
        chk("ovf_ack_clr", 32'(bus.ovf), 0);
        bus.ack = '0; step();
        chk("ovf_irq_idle", 32'(bus.irq), 0);

        // Hold-off of 5 cycles; a change during HOLD must not matter
        bus.holdoff_cycles = 8'd5;
        bus.src = 3'b001; step();
        bus.src = '0; step();
        chk("ho5_irq", 32'(bus.irq), 1);
        bus.ack = 3'b001; step();
        bus.ack = '0; bus.src = 3'b001; step();
        chk("ho5_drop", 32'(bus.irq), 0);
        chk("ho5_refire", 32'(bus.pending), 32'h1);
        bus.src = '0; bus.holdoff_cycles = 8'd9;
        low = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.irq) break;
            low++;
        end
        chk("ho5_low_cycles", 32'(low), 6);

        // Hold-off of 0
        bus.holdoff_cycles = 8'd0;
        bus.ack = 3'b001; step();
        bus.ack = '0; bus.src = 3'b001; step();
        chk("ho0_drop", 32'(bus.irq), 0);
        bus.src = '0;
        low = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.irq) break;
            low++;
        end
        chk("ho0_low_cycles", 32'(low), 1);
        bus.ack = 3'b001; step();
        bus.ack = '0; step();
        chk("ho0_idle", 32'(bus.irq), 0);

        // Masking and priority
        bus.en = 3'b100; bus.src = 3'b110; step();
        bus.src = '0; step();
        chk("mask_pend", 32'(bus.pending), 32'h6);
        chk("mask_irq", 32'(bus.irq), 1);
        chk("mask_cause2", 32'(bus.irq_cause), 2);
        bus.en = 3'b110; step();
        chk("mask_cause1", 32'(bus.irq_cause), 1);
        bus.en = 3'b000; step();
        chk("mask_off_irq", 32'(bus.irq), 0);
        chk("mask_off_pend", 32'(bus.pending), 32'h6);
        chk("mask_off_cause", 32'(bus.irq_cause), 0);
        bus.en = 3'b010; step();
        chk("reenable_irq", 32'(bus.irq), 1);
        chk("reenable_cause", 32'(bus.irq_cause), 1);
        bus.ack = 3'b110; step();
        bus.ack = '0; bus.en = 3'b111; step(); step();
        chk("mask_clean", 32'(bus.irq), 0);

        // Reset in the middle of HOLD
        bus.holdoff_cycles = 8'd5;
        bus.src = 3'b001; step();
        bus.src = '0; step();
        bus.ack = 3'b001; step();
        bus.ack = '0; bus.src = 3'b001; step();
        bus.src = '0; step(); step();
        chk("hold_pend", 32'(bus.pending), 32'h1);
        rst = 1'b1; step();
        chk("mrst_pend", 32'(bus.pending), 0);
        chk("mrst_irq", 32'(bus.irq), 0);
        chk("mrst_cause", 32'(bus.irq_cause), 0);
        chk("mrst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mrst_no_irq", 32'(bus.irq), 0);
        end
        // After reset, pending must also take the normal 2-edge path.
        bus.src = 3'b001; step();
        bus.src = '0;
        chk("post_rst_irq0", 32'(bus.irq), 0);
        step();
        chk("post_rst_irq1", 32'(bus.irq), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsqw_irq_ctrl_mc.md
Name: dsqw_irq_ctrl_mc

Overview:
- Parametrised multi-channel interrupt controller for the deskew IP; next generation of the three-source sticky IRQ block.
- Collects N event sources (done, size error, memory access error, plus future sources) into sticky pending bits.
- Each source has a per-channel enable and a per-channel edge/level mode.
- Drives one registered interrupt line with a programmable hold-off gap between consecutive interrupts, and reports the lowest-index active cause.

Parameters:
- N_SRC, 3, number of interrupt sources (1..32).
- CNT_W, 8, width of hold-off counter and holdoff_cycles input.
- IDX_W, $clog2(N_SRC) (min 1), width of irq_cause.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- src  in  N_SRC  raw event inputs, synchronous to clk.
- ack  in  N_SRC  per-source clear pulse (write-1-to-clear from register block).
- en  in  N_SRC  per-source enable; masks irq only, never pending capture.
- edge_mode  in  N_SRC  1 = rising-edge detect, 0 = level (src high each cycle is an event).
- holdoff_cycles  in  CNT_W  minimum idle cycles between irq deassert and next assert; 0 = none.
- pending  out  N_SRC  sticky pending bits.
- irq  out  1  registered interrupt output.
- irq_cause  out  IDX_W  index of lowest set bit of (pending & en); 0 when none.
- ovf  out  N_SRC  sticky overflow flags (see Optional Feature).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): pending=0, src_d=0, irq=0, irq_cause=0, ovf=0, FSM=IDLE, counter=0. Reset mid-hold-off aborts the hold-off immediately.
- Event per channel i: edge_mode[i] ? (src[i] & ~src_d[i]) : src[i]; src_d registered every cycle.
- pending[i] next = ack[i] ? 0 : (event[i] ? 1 : pending[i]).
  - Ack has priority over a simultaneous event; that event is lost (and counted as overflow, see below).
  - Level source still high after ack re-sets pending on the following edge.
- active = |(pending & en), computed from registered pending.
- irq_cause is registered alongside irq and updated every cycle as a priority encode, lowest index wins.
- Latency: src high at edge k -> pending=1 after edge k -> irq=1 after edge k+1 (2 edges) when FSM is IDLE.
- FSM, irq registered from state:
  - IDLE (irq=0): active -> ASSERT.
  - ASSERT (irq=1): ~active -> HOLD if holdoff_cycles!=0, counter loaded with holdoff_cycles; else -> IDLE.
  - HOLD (irq=0): counter decrements each cycle; counter==1 -> IDLE. Events during HOLD still set pending; irq reasserts only from IDLE.
- holdoff_cycles is sampled only on entry to HOLD; later changes do not affect the running count.
- Clearing en[i] while in ASSERT with no other active source behaves as ~active: irq drops on the next edge.
- Enabling a source whose pending bit is already set triggers irq as normal (2-edge path via IDLE).
- N_SRC=1: irq_cause is 1 bit, constant 0.

Optional Feature:
- Macro DSQW_IRQ_OVF_EN.
- Defined: ovf[i] set when event[i]=1 while pending[i]=1, or when event[i] and ack[i] coincide. ovf[i] is cleared by ack[i] unless set again in the same cycle; set wins.
- Undefined: ovf tied to 0; no storage is inferred; the port remains.

Decomposition:
- Package dsqw_irq_pkg:
  - FSM state encoding (IDLE, ASSERT, HOLD).
  - Default widths, and an index-width helper function returning max(1, clog2(n)).
- Sub-module dsqw_irq_chan: one channel's src_d, edge/level detect, pending and ovf bit, instantiated N_SRC times by generate.
- Top holds the priority encoder, FSM and hold-off counter.

Test Plan:
- Reset/level path: N_SRC=3, en=3'b111, edge_mode=0, src[1] pulsed 1 cycle -> pending=3'b010 after 1 edge; irq=1, irq_cause=1 after 2 edges; ack[1] -> pending=0 next edge, irq=0 the edge after.
- Edge mode: edge_mode[0]=1, src[0] held high 10 cycles, ack[0] at cycle 4 -> pending[0] set once and stays 0 after ack; irq does not reassert.
- Simultaneous ack and event on ch2 -> pending[2]=0. With DSQW_IRQ_OVF_EN, ovf[2]=1. Without the macro, ovf=0.
- Hold-off: holdoff_cycles=5, ch0 acked, ch0 re-fires 1 cycle later -> irq low exactly 5 cycles, then reasserts after IDLE (+1 edge); holdoff_cycles=0 -> irq low 1 cycle only.
- Masking and priority: pending=3'b110, en=3'b100 -> irq_cause=2. Set en=3'b110 -> irq_cause=1. Set en=0 -> irq=0 next edge, pending unchanged.
- Reset mid-HOLD with counter=3 and pending=3'b001 -> all outputs 0, FSM IDLE on the next edge, no residual irq.
